branch_resolve_unit: RTL and testbench

Tracks every conditional branch from fetch (where the 1-bit, 16-entry branch predictor supplies a prediction) to execute (where the actual outcome is known). It holds in-flight predictions in a small in-order queue and compares each one against the resolved outcome. It then drives the predictor's update port (enable, index, {predicted, actual} pair) and issues a PC redirect with a queue flush on a misprediction. It is the writer side of the predictor's update interface.

---
 rtl/branch_resolve_unit_pkg.sv | 31 +++
 rtl/branch_resolve_unit_fifo.sv | 59 +++++
 rtl/branch_resolve_unit.sv | 118 +++++++++++
 tb/tb_branch_resolve_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit:
// FSM states, {predicted,actual} codes, entry field widths.
package branch_resolve_unit_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } bru_state_e;

  localparam logic [1:0] PA_HIT_NT  = 2'b00;
  localparam logic [1:0] PA_MISS_T  = 2'b01;
  localparam logic [1:0] PA_MISS_NT = 2'b10;
  localparam logic [1:0] PA_HIT_T   = 2'b11;

  localparam int TAKEN_W = 1;

  function automatic int entry_w(
    input int idx_w,
    input int pc_w
  );
    return idx_w + TAKEN_W + pc_w;
  endfunction

  function automatic logic is_miss(
    input logic [1:0] pa
  );
    return (pa == PA_MISS_T) ||
           (pa == PA_MISS_NT);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_fifo.sv
// In-order synchronous FIFO with push, pop and flush.
// Ports: Clock, Reset, push/pop/flush, wdata, rdata (head), full, empty.
import branch_resolve_unit_pkg::*;

module branch_resolve_unit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Flush wins over everything: younger entries are wrong-path.
  always_ff @(posedge Clock) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches branch predictions against resolved outcomes, updates predictor.
// Ports: Pred* push side, Res* resolve side, Upd* predictor update,
// Redirect/RedirectPC on mispredict, sticky Underflow.
// Optional BRU_STATS_EN adds BranchCount/MissCount saturating counters.
import branch_resolve_unit_pkg::*;

module branch_resolve_unit #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             PredValid,
  input  logic [IDX_W-1:0] PredIndex,
  input  logic             PredTaken,
  input  logic [PC_W-1:0]  PredAltPC,
  output logic             PredReady,
  input  logic             ResValid,
  input  logic             ResTaken,
  output logic             UpdEn,
  output logic [IDX_W-1:0] UpdIndex,
  output logic [1:0]       UpdPredActual,
  output logic             Redirect,
  output logic [PC_W-1:0]  RedirectPC,
`ifdef BRU_STATS_EN
  output logic [15:0]      BranchCount,
  output logic [15:0]      MissCount,
`endif
  output logic             Underflow
);

  localparam int EW = entry_w(IDX_W, PC_W);

  bru_state_e       state;
  logic [EW-1:0]    head;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [PC_W-1:0]  head_alt;
  logic             full;
  logic             empty;
  logic             in_run;
  logic             push_ok;
  logic             resolve;
  logic             miss;
  logic [1:0]       pa;

  assign {head_idx, head_taken, head_alt} = head;

  assign in_run    = (state == ST_RUN);
  assign PredReady = !full && in_run && !Reset;
  assign push_ok   = PredValid && PredReady;
  assign resolve   = ResValid && in_run && !empty;
  assign pa        = {head_taken, ResTaken};
  assign miss      = resolve && is_miss(pa);

  branch_resolve_unit_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push_ok && !miss),
    .pop   (resolve),
    .flush (miss),
    .wdata ({PredIndex, PredTaken, PredAltPC}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= ST_RUN;
      UpdEn         <= 1'b0;
      UpdIndex      <= '0;
      UpdPredActual <= 2'b00;
      Redirect      <= 1'b0;
      RedirectPC    <= '0;
      Underflow     <= 1'b0;
    end else begin
      UpdEn         <= resolve;
      UpdPredActual <= resolve ? pa : 2'b00;
      Redirect      <= miss;
      if (resolve) begin
        UpdIndex <= head_idx;
      end
      if (miss) begin
        RedirectPC <= head_alt;
      end
      if (ResValid && in_run && empty) begin
        Underflow <= 1'b1;
      end
      unique case (state)
        ST_RUN:     state <= miss ? ST_RECOVER : ST_RUN;
        ST_RECOVER: state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      BranchCount <= '0;
      MissCount   <= '0;
    end else begin
      if (resolve && BranchCount != 16'hFFFF) begin
        BranchCount <= BranchCount + 16'd1;
      end
      if (miss && MissCount != 16'hFFFF) begin
        MissCount <= MissCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Inputs driven #1 after the rising edge; outputs sampled there too.
module tb_branch_resolve_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        PredValid;
  logic [3:0]  PredIndex;
  logic        PredTaken;
  logic [31:0] PredAltPC;
  logic        PredReady;
  logic        ResValid;
  logic        ResTaken;
  logic        UpdEn;
  logic [3:0]  UpdIndex;
  logic [1:0]  UpdPredActual;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Underflow;
`ifdef BRU_STATS_EN
  logic [15:0] BranchCount;
  logic [15:0] MissCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  branch_resolve_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .PredValid     (PredValid),
    .PredIndex     (PredIndex),
    .PredTaken     (PredTaken),
    .PredAltPC     (PredAltPC),
    .PredReady     (PredReady),
    .ResValid      (ResValid),
    .ResTaken      (ResTaken),
    .UpdEn         (UpdEn),
    .UpdIndex      (UpdIndex),
    .UpdPredActual (UpdPredActual),
    .Redirect      (Redirect),
    .RedirectPC    (RedirectPC),
`ifdef BRU_STATS_EN
    .BranchCount   (BranchCount),
    .MissCount     (MissCount),
`endif
    .Underflow     (Underflow)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(
    input logic [3:0]  idx,
    input logic        tk,
    input logic [31:0] alt
  );
    PredValid = 1'b1;
    PredIndex = idx;
    PredTaken = tk;
    PredAltPC = alt;
  endtask

  initial begin
    Reset     = 1'b1;
    PredValid = 1'b0;
    PredIndex = '0;
    PredTaken = 1'b0;
    PredAltPC = '0;
    ResValid  = 1'b0;
    ResTaken  = 1'b0;
    step();
    step();
    check("rst_ready", 32'(PredReady), 0);
    check("rst_upden", 32'(UpdEn), 0);
    check("rst_pa", 32'(UpdPredActual), 0);
    check("rst_redir", 32'(Redirect), 0);
    check("rst_rpc", RedirectPC, 0);
    check("rst_uflow", 32'(Underflow), 0);
    Reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(PredReady), 1);

    // correct taken prediction
    push(4'd3, 1'b1, 32'h100);
    step();
    PredValid = 1'b0;
    ResValid  = 1'b1;
    ResTaken  = 1'b1;
    step();
    ResValid = 1'b0;
    check("t1_upden", 32'(UpdEn), 1);
    check("t1_idx", 32'(UpdIndex), 3);
    check("t1_pa", 32'(UpdPredActual), 32'h3);
    check("t1_redir", 32'(Redirect), 0);
`ifdef BRU_STATS_EN
    check("t1_bcnt", 32'(BranchCount), 1);
    check("t1_mcnt", 32'(MissCount), 0);
`endif
    step();
    check("t1_upden_off", 32'(UpdEn), 0);
    check("t1_pa_off", 32'(UpdPredActual), 0);

    // mispredict: predicted not-taken, actually taken
    push(4'd5, 1'b0, 32'h240);
    step();
    push(4'd6, 1'b1, 32'h300);
    step();
    PredValid = 1'b0;
    ResValid  = 1'b1;
    ResTaken  = 1'b1;
    step();
    ResValid = 1'b0;
    check("t2_pa", 32'(UpdPredActual), 32'h1);
    check("t2_idx", 32'(UpdIndex), 5);
    check("t2_redir", 32'(Redirect), 1);
    check("t2_rpc", RedirectPC, 32'h240);
    check("t2_recover_ready", 32'(PredReady), 0);
`ifdef BRU_STATS_EN
    check("t2_mcnt", 32'(MissCount), 1);
`endif
    step();
    check("t2_redir_off", 32'(Redirect), 0);
    check("t2_run_ready", 32'(PredReady), 1);

    // fill to DEPTH; a leftover idx 6 would fill it one push early
    for (int i = 0; i < 4; i++) begin
      check("t3_ready_fill", 32'(PredReady), 1);
      push(4'(i), 1'b1, 32'h1000 + 32'(i));
      step();
    end
    push(4'd4, 1'b1, 32'h2000);
    check("t3_full", 32'(PredReady), 0);
    step();
    PredValid = 1'b0;
    ResValid  = 1'b1;
    ResTaken  = 1'b1;
    step();
    check("t3_pop0", 32'(UpdIndex), 0);
    check("t3_ready_again", 32'(PredReady), 1);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t3_upden", 32'(UpdEn), 1);
      check("t3_order", 32'(UpdIndex), 32'(i));
    end

    // queue now empty: the fifth push must not be there
    step();
    ResValid = 1'b0;
    check("t4_no_upd", 32'(UpdEn), 0);
    check("t4_uflow", 32'(Underflow), 1);
    step();
    step();
    check("t4_uflow_sticky", 32'(Underflow), 1);

    // mispredict with a same-cycle push of idx 9
    push(4'd7, 1'b0, 32'h500);
    step();
    push(4'd9, 1'b1, 32'h900);
    ResValid = 1'b1;
    ResTaken = 1'b1;
    step();
    PredValid = 1'b0;
    check("t5_redir", 32'(Redirect), 1);
    check("t5_rpc", RedirectPC, 32'h500);
    step();
    check("t5_recover_noupd", 32'(UpdEn), 0);
    step();
    ResValid = 1'b0;
    check("t5_push_dropped", 32'(UpdEn), 0);

    // reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      push(4'(10 + i), 1'b1, 32'h0);
      step();
    end
    PredValid = 1'b0;
    Reset     = 1'b1;
    step();
    check("t6_ready", 32'(PredReady), 0);
    check("t6_upden", 32'(UpdEn), 0);
    check("t6_idx", 32'(UpdIndex), 0);
    check("t6_redir", 32'(Redirect), 0);
    check("t6_rpc", RedirectPC, 0);
    check("t6_uflow", 32'(Underflow), 0);
`ifdef BRU_STATS_EN
    check("t6_bcnt", 32'(BranchCount), 0);
    check("t6_mcnt", 32'(MissCount), 0);
`endif
    Reset    = 1'b0;
    ResValid = 1'b1;
    ResTaken = 1'b1;
    step();
    ResValid = 1'b0;
    check("t6_empty_noupd", 32'(UpdEn), 0);
    check("t6_empty_uflow", 32'(Underflow), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
